// File: rtl/hw_lcd_responder.sv
// HD44780-style 8-bit character-LCD bus responder: 80-byte DDRAM, address counter,
// busy flag, read-back drive, and a registered read-only scan port for a character scanner.
module hw_lcd_responder #(
  parameter int unsigned BUSY_CYCLES = 50,
  parameter int unsigned HOME_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  inout  wire  [7:0] LCD_data,
  input  logic [6:0] scan_addr,
  output logic [7:0] scan_char,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] cursor_addr,
  output logic       busy,
  output logic       protocol_err
);

  localparam int unsigned DEPTH   = 80;
  localparam int unsigned MAX_CYC = (HOME_CYCLES > BUSY_CYCLES) ? HOME_CYCLES : BUSY_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  // 2-line AC format -> linear DDRAM index
  function automatic logic [6:0] ac_lin(input logic [6:0] ac);
    return ac[6] ? (7'(ac[5:0]) + 7'd40) : 7'(ac[5:0]);
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      r = 7'h67;
      else if (ac == 7'h40) r = 7'h27;
      else                  r = ac - 7'd1;
    end
    return r;
  endfunction

  logic             e_s1_q, e_s2_q, e_dly_q;
  logic             rs_s1_q, rs_s2_q, rs_dly_q;
  logic             rw_s1_q, rw_s2_q, rw_dly_q;
  logic [7:0]       dat_s1_q, dat_s2_q, dat_dly_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       fill_q, fill_d;
  logic             fill_home_q, fill_home_d;
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic             cg_q, cg_d;
  logic             perr_q, perr_d;
  logic             busy_q;
  logic [6:0]       cursor_q;
  logic             rd_en_q;
  logic [7:0]       rd_data_q;
  logic [7:0]       scan_q;

  logic [7:0]       mem [DEPTH];
  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [7:0]       mem_wdata;

  logic             commit_c, status_rd_c, rd_start_c;

  assign commit_c    = e_dly_q & ~e_s2_q;
  assign status_rd_c = ~rs_dly_q & rw_dly_q;
  assign rd_start_c  = e_s2_q & rw_s2_q & ~rd_en_q;

  // Next-state: fill/busy sequencing plus command decode on the committed E fall
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    fill_home_d = fill_home_q;
    ac_d        = ac_q;
    id_d        = id_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    cg_d        = cg_q;
    perr_d      = perr_q;
    mem_we      = 1'b0;
    mem_waddr   = ac_lin(ac_q);
    mem_wdata   = dat_dly_q;

    case (state_q)
      S_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = fill_q;
        mem_wdata = 8'h20;
        if (fill_q == 7'(DEPTH - 1)) begin
          fill_d  = 7'd0;
          state_d = fill_home_q ? S_BUSY : S_IDLE;
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    if (commit_c && !status_rd_c) begin
      if (state_q != S_IDLE) begin
        perr_d = 1'b1;
      end else begin
        state_d = S_BUSY;
        cnt_d   = CNT_W'(BUSY_CYCLES - 1);
        if (!rs_dly_q) begin
          casez (dat_dly_q)
            8'b1???????: begin
              cg_d = 1'b0;
              ac_d = {dat_dly_q[6], (dat_dly_q[5:0] > 6'h27) ? 6'h27 : dat_dly_q[5:0]};
            end
            8'b01??????: cg_d = 1'b1;
            8'b001?????: ;
            8'b0001????: if (!dat_dly_q[3]) ac_d = ac_step(ac_q, dat_dly_q[2]);
            8'b00001???: begin
              disp_d  = dat_dly_q[2];
              cur_d   = dat_dly_q[1];
              blink_d = dat_dly_q[0];
            end
            8'b000001??: id_d = dat_dly_q[1];
            8'b0000001?: begin
              ac_d  = 7'd0;
              cnt_d = CNT_W'(HOME_CYCLES - 1);
            end
            8'b00000001: begin
              state_d     = S_FILL;
              fill_d      = 7'd0;
              fill_home_d = 1'b1;
              ac_d        = 7'd0;
              id_d        = 1'b1;
              cnt_d       = CNT_W'(HOME_CYCLES - 1);
            end
            default: ;
          endcase
        end else if (!cg_q) begin
          mem_we = ~rw_dly_q;
          ac_d   = ac_step(ac_q, id_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {e_s1_q, e_s2_q, e_dly_q}    <= 3'b000;
      {rs_s1_q, rs_s2_q, rs_dly_q} <= 3'b000;
      {rw_s1_q, rw_s2_q, rw_dly_q} <= 3'b000;
      dat_s1_q    <= 8'h00;
      dat_s2_q    <= 8'h00;
      dat_dly_q   <= 8'h00;
      state_q     <= S_FILL;
      cnt_q       <= '0;
      fill_q      <= 7'd0;
      fill_home_q <= 1'b0;
      ac_q        <= 7'd0;
      id_q        <= 1'b1;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      cg_q        <= 1'b0;
      perr_q      <= 1'b0;
      busy_q      <= 1'b1;
      cursor_q    <= 7'd0;
      rd_en_q     <= 1'b0;
      rd_data_q   <= 8'h00;
      scan_q      <= 8'h00;
    end else begin
      {e_s1_q, e_s2_q, e_dly_q}    <= {LCD_E, e_s1_q, e_s2_q};
      {rs_s1_q, rs_s2_q, rs_dly_q} <= {LCD_RS, rs_s1_q, rs_s2_q};
      {rw_s1_q, rw_s2_q, rw_dly_q} <= {LCD_RW, rw_s1_q, rw_s2_q};
      dat_s1_q    <= LCD_data;
      dat_s2_q    <= dat_s1_q;
      dat_dly_q   <= dat_s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      fill_home_q <= fill_home_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      cg_q        <= cg_d;
      perr_q      <= perr_d;
      busy_q      <= (state_d != S_IDLE);
      cursor_q    <= ac_lin(ac_d);
      rd_en_q     <= e_s2_q & rw_s2_q;
      // Read data is frozen at the start of the drive window
      if (rd_start_c) begin
        if (rs_s2_q) rd_data_q <= cg_q ? 8'h00 : mem[ac_lin(ac_q)];
        else         rd_data_q <= {busy_q, ac_q};
      end
      scan_q      <= (scan_addr < 7'(DEPTH)) ? mem[scan_addr] : 8'h00;
    end
  end

  // DDRAM has no reset; the FILL sequence initialises it
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign LCD_data     = rd_en_q ? rd_data_q : 8'hzz;
  assign scan_char    = scan_q;
  assign disp_on      = disp_q;
  assign cursor_on    = cur_q;
  assign blink_on     = blink_q;
  assign cursor_addr  = cursor_q;
  assign busy         = busy_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_hw_lcd_responder.sv
// Directed bench for hw_lcd_responder: bus writes/reads through the synchronised
// LCD bus, expected values hand-computed from the HD44780 AC/DDRAM rules.
module tb_hw_lcd_responder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] lcd_data;
  logic [6:0] scan_addr = 7'd0;
  logic [7:0] scan_char;
  logic       disp_on, cursor_on, blink_on, busy, protocol_err;
  logic [6:0] cursor_addr;

  int n_checks = 0;
  int n_fail   = 0;

  assign lcd_data = drv_en ? drv : 8'hzz;

  hw_lcd_responder #(.BUSY_CYCLES(50), .HOME_CYCLES(1600)) dut (
    .clk(clk), .reset_n(reset_n), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_data(lcd_data), .scan_addr(scan_addr), .scan_char(scan_char),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .cursor_addr(cursor_addr), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = 1'b0; drv = d; drv_en = 1'b1; lcd_e = 1'b1;
    repeat (4) @(posedge clk);
    #1 lcd_e = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    repeat (5) @(posedge clk);
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%0b after 3000 cycles, required 0", busy);
    end
  endtask

  task automatic write_wait(input logic rs, input logic [7:0] d);
    bus_write(rs, d);
    wait_idle();
  endtask

  // Read cycle; rel_ok reports whether the DUT let go of the bus afterwards
  task automatic bus_read(input logic rs, output logic [7:0] d, output logic rel_ok);
    @(posedge clk); #1;
    drv_en = 1'b0; lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); d = lcd_data;
    @(posedge clk); #1 lcd_e = 1'b0;
    repeat (4) @(posedge clk);
    #1 drv = 8'h00; drv_en = 1'b1;
    #1 rel_ok = (lcd_data === 8'h00);
    @(posedge clk); #1 lcd_rw = 1'b0;
  endtask

  task automatic scan_rd(input int a, output logic [7:0] d);
    @(posedge clk); #1 scan_addr = 7'(a);
    @(posedge clk); @(negedge clk);
    d = scan_char;
  endtask

  task automatic measure_busy(output int n);
    logic seen, done;
    n = 0; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (busy) begin n++; seen = 1'b1; end
      else if (seen) done = 1'b1;
    end
  endtask

  task automatic status_is(input string name, input logic [7:0] exp);
    logic [7:0] v; logic r;
    bus_read(1'b0, v, r);
    n_checks++;
    if (v !== exp) begin n_fail++; $display("FAIL %s: status=%h required %h", name, v, exp); end
  endtask

  task automatic test_reset();
    int n; logic [7:0] v;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || scan_char !== 8'h00) begin
      n_fail++; $display("FAIL reset_vals: busy=%b scan=%h required 1 00", busy, scan_char);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    measure_busy(n);
    n_checks++;
    if (n !== 80) begin n_fail++; $display("FAIL reset_fill_busy: %0d cycles required 80", n); end
    n_checks++;
    if ({disp_on, cursor_on, blink_on, protocol_err} !== 4'b0000 || cursor_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outs: d/c/b/perr=%b%b%b%b cursor=%0d required 0000 0",
               disp_on, cursor_on, blink_on, protocol_err, cursor_addr);
    end
    for (int a = 0; a < 80; a++) begin
      scan_rd(a, v);
      n_checks++;
      if (v !== 8'h20) begin n_fail++; $display("FAIL reset_scan[%0d]: %h required 20", a, v); end
    end
    status_is("reset_status", 8'h00);
  endtask

  task automatic test_data_write();
    int n; logic [7:0] v;
    write_wait(1'b0, 8'h80);
    bus_write(1'b1, 8'h41);
    measure_busy(n);
    n_checks++;
    if (n !== 50) begin n_fail++; $display("FAIL write_busy_len: %0d cycles required 50", n); end
    write_wait(1'b1, 8'h42);
    scan_rd(0, v);
    n_checks++;
    if (v !== 8'h41) begin n_fail++; $display("FAIL wr_ddram0: %h required 41", v); end
    scan_rd(1, v);
    n_checks++;
    if (v !== 8'h42) begin n_fail++; $display("FAIL wr_ddram1: %h required 42", v); end
    n_checks++;
    if (cursor_addr !== 7'd2) begin n_fail++; $display("FAIL wr_cursor: %0d required 2", cursor_addr); end
    status_is("wr_status", 8'h02);
  endtask

  task automatic test_line_wrap();
    logic [7:0] v;
    write_wait(1'b0, 8'hA7);
    n_checks++;
    if (cursor_addr !== 7'd39) begin n_fail++; $display("FAIL wrap_setaddr: %0d required 39", cursor_addr); end
    write_wait(1'b1, 8'h58);
    scan_rd(39, v);
    n_checks++;
    if (v !== 8'h58) begin n_fail++; $display("FAIL wrap_ddram39: %h required 58", v); end
    n_checks++;
    if (cursor_addr !== 7'd40) begin n_fail++; $display("FAIL wrap_line1_cursor: %0d required 40", cursor_addr); end
    status_is("wrap_line1_status", 8'h40);
    write_wait(1'b0, 8'hE7);
    write_wait(1'b1, 8'h59);
    scan_rd(79, v);
    n_checks++;
    if (v !== 8'h59) begin n_fail++; $display("FAIL wrap_ddram79: %h required 59", v); end
    n_checks++;
    if (cursor_addr !== 7'd0) begin n_fail++; $display("FAIL wrap_end_cursor: %0d required 0", cursor_addr); end
    status_is("wrap_end_status", 8'h00);
  endtask

  task automatic test_decrement();
    logic [7:0] v;
    write_wait(1'b0, 8'h04);
    write_wait(1'b0, 8'hC0);
    write_wait(1'b1, 8'h5A);
    scan_rd(40, v);
    n_checks++;
    if (v !== 8'h5A) begin n_fail++; $display("FAIL dec_ddram40: %h required 5A", v); end
    n_checks++;
    if (cursor_addr !== 7'd39) begin n_fail++; $display("FAIL dec_cursor: %0d required 39", cursor_addr); end
    status_is("dec_status", 8'h27);
    write_wait(1'b0, 8'h06);
  endtask

  task automatic test_clamp_shift();
    write_wait(1'b0, 8'hBF);
    status_is("clamp_line0", 8'h27);
    write_wait(1'b0, 8'hFF);
    status_is("clamp_line1", 8'h67);
    write_wait(1'b0, 8'h80);
    write_wait(1'b0, 8'h14);
    status_is("shift_right", 8'h01);
    write_wait(1'b0, 8'h10);
    write_wait(1'b0, 8'h10);
    status_is("shift_left_wrap", 8'h67);
    write_wait(1'b0, 8'h14);
    status_is("shift_right_wrap", 8'h00);
    write_wait(1'b0, 8'h1C);
    status_is("shift_display_noop", 8'h00);
  endtask

  task automatic test_data_read();
    logic [7:0] v; logic r;
    bus_read(1'b1, v, r);
    n_checks++;
    if (v !== 8'h41) begin n_fail++; $display("FAIL rd_data0: %h required 41", v); end
    n_checks++;
    if (r !== 1'b1) begin n_fail++; $display("FAIL rd_release: released=%b required 1", r); end
    wait_idle();
    status_is("rd_ac_step", 8'h01);
    bus_read(1'b1, v, r);
    n_checks++;
    if (v !== 8'h42) begin n_fail++; $display("FAIL rd_data1: %h required 42", v); end
    wait_idle();
  endtask

  task automatic test_cgram();
    logic [7:0] v; logic r;
    write_wait(1'b0, 8'h80);
    write_wait(1'b0, 8'h40);
    write_wait(1'b1, 8'h77);
    scan_rd(0, v);
    n_checks++;
    if (v !== 8'h41) begin n_fail++; $display("FAIL cg_write_blocked: %h required 41", v); end
    status_is("cg_ac_hold", 8'h00);
    bus_read(1'b1, v, r);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL cg_read_zero: %h required 00", v); end
    wait_idle();
    status_is("cg_read_ac_hold", 8'h00);
    write_wait(1'b0, 8'h81);
    write_wait(1'b1, 8'h43);
    scan_rd(1, v);
    n_checks++;
    if (v !== 8'h43) begin n_fail++; $display("FAIL cg_exit_write: %h required 43", v); end
  endtask

  task automatic test_busy_violation();
    logic [7:0] v;
    n_checks++;
    if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL perr_pre: %b required 0", protocol_err); end
    bus_write(1'b0, 8'h80);
    repeat (4) @(posedge clk);
    status_is("status_while_busy", 8'h80);
    @(negedge clk);
    n_checks++;
    if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL perr_status: %b required 0", protocol_err); end
    bus_write(1'b1, 8'h33);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: %b required 1", protocol_err); end
    wait_idle();
    scan_rd(0, v);
    n_checks++;
    if (v !== 8'h41) begin n_fail++; $display("FAIL busy_write_dropped: %h required 41", v); end
    status_is("busy_write_no_ac", 8'h00);
  endtask

  task automatic test_display_ctrl();
    write_wait(1'b0, 8'h0D);
    n_checks++;
    if ({disp_on, cursor_on, blink_on} !== 3'b101) begin
      n_fail++; $display("FAIL dispctl_0D: %b%b%b required 101", disp_on, cursor_on, blink_on);
    end
    write_wait(1'b0, 8'h0F);
    n_checks++;
    if ({disp_on, cursor_on, blink_on} !== 3'b111) begin
      n_fail++; $display("FAIL dispctl_0F: %b%b%b required 111", disp_on, cursor_on, blink_on);
    end
  endtask

  task automatic test_clear_home();
    int n; logic [7:0] v;
    write_wait(1'b0, 8'h04);
    bus_write(1'b0, 8'h01);
    measure_busy(n);
    n_checks++;
    if (n !== 1680) begin n_fail++; $display("FAIL clear_busy_len: %0d cycles required 1680", n); end
    for (int a = 0; a < 80; a++) begin
      scan_rd(a, v);
      n_checks++;
      if (v !== 8'h20) begin n_fail++; $display("FAIL clear_scan[%0d]: %h required 20", a, v); end
    end
    n_checks++;
    if (cursor_addr !== 7'd0 || disp_on !== 1'b1 || protocol_err !== 1'b1) begin
      n_fail++; $display("FAIL clear_state: cursor=%0d disp=%b perr=%b required 0 1 1",
                         cursor_addr, disp_on, protocol_err);
    end
    write_wait(1'b1, 8'h61);
    status_is("clear_sets_inc", 8'h01);
    bus_write(1'b0, 8'h02);
    measure_busy(n);
    n_checks++;
    if (n !== 1600) begin n_fail++; $display("FAIL home_busy_len: %0d cycles required 1600", n); end
    status_is("home_ac", 8'h00);
    scan_rd(0, v);
    n_checks++;
    if (v !== 8'h61) begin n_fail++; $display("FAIL home_keeps_ddram: %h required 61", v); end
  endtask

  task automatic test_reset_mid_clear();
    int n; logic [7:0] v;
    write_wait(1'b0, 8'hE7);
    write_wait(1'b1, 8'h7A);
    bus_write(1'b0, 8'h01);
    repeat (30) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || disp_on !== 1'b0 || protocol_err !== 1'b0 || cursor_addr !== 7'd0) begin
      n_fail++; $display("FAIL midreset_vals: busy=%b disp=%b perr=%b cursor=%0d required 1 0 0 0",
                         busy, disp_on, protocol_err, cursor_addr);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    measure_busy(n);
    n_checks++;
    if (n !== 80) begin n_fail++; $display("FAIL midreset_fill: %0d cycles required 80", n); end
    scan_rd(79, v);
    n_checks++;
    if (v !== 8'h20) begin n_fail++; $display("FAIL midreset_ddram79: %h required 20", v); end
    status_is("midreset_status", 8'h00);
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_line_wrap();
    test_decrement();
    test_clamp_shift();
    write_wait(1'b0, 8'h80);
    test_data_read();
    test_cgram();
    test_busy_violation();
    test_display_ctrl();
    test_clear_home();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
